// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART types and helpers, used by both the receiver and the matching transmitter.
package uart_rx_deserializer_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line in, received byte plus status strobes out; slave is the deserializer side.
interface uart_rx_deserializer_if;
  import uart_rx_deserializer_pkg::*;

  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output uart_rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  uart_rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_deserializer_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 (idle line level), 2-cycle latency.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: mid-bit sampling of 8N1 frames (8E1/8O1 when UART_RX_PARITY_EN is defined).
// Strobes fire one cycle after the mid-stop sample; no backpressure, the consumer must capture on rx_valid.
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic                   clk,
  input logic                   reset,
  uart_rx_deserializer_if.slave rx_if
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync2 u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (rx_if.uart_rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      // A start bit still low at its midpoint is real; anything shorter is a glitch.
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at default 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_rx_deserializer;

  localparam int CPB  = 434;
  localparam int HALF = 217;
`ifdef UART_RX_PARITY_EN
  localparam int  FRAME_BITS = 11;
  localparam logic PAR_ODD   = 1'b0;
`else
  localparam int  FRAME_BITS = 10;
`endif
  localparam int STROBE_LAT = 3 + HALF + (FRAME_BITS - 1) * CPB;

  logic clk = 1'b0;
  logic reset;

  uart_rx_deserializer_if u_if ();

  uart_rx_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0;
  int         last_valid_cyc = 0, prev_valid_cyc = 0;
  logic [7:0] last_valid_data = '0, prev_valid_data = '0;

  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      n_valid++;
      prev_valid_cyc  = last_valid_cyc;
      last_valid_cyc  = cyc;
      prev_valid_data = last_valid_data;
      last_valid_data = u_if.rx_data;
    end
    if (u_if.frame_err === 1'b1)  n_ferr++;
    if (u_if.parity_err === 1'b1) n_perr++;
    if (int'(u_if.rx_valid === 1'b1) + int'(u_if.frame_err === 1'b1)
        + int'(u_if.parity_err === 1'b1) > 1) n_multi++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    u_if.uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD);
`endif
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, f0, p0, c0;

    vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'hA5, 1'b0, 0, 1, 8'h81};
    vecs[4] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

    u_if.uart_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_data", u_if.rx_data, 8'h00);
    check("reset rx_valid", u_if.rx_valid, 1'b0);
    check("reset frame_err", u_if.frame_err, 1'b0);
    check("reset parity_err", u_if.parity_err, 1'b0);
    check("reset busy", u_if.busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle busy", u_if.busy, 1'b0);

    // Single 0x55 frame with exact strobe latency
    v0 = n_valid; f0 = n_ferr; c0 = cyc;
    send_frame(8'h55, 1'b1);
    check("t1 busy after stop", u_if.busy, 1'b0);
    drive_bit(1'b1);
    check("t1 valid count", n_valid - v0, 1);
    check("t1 ferr count", n_ferr - f0, 0);
    check("t1 rx_data", u_if.rx_data, 8'h55);
    check("t1 strobe latency", last_valid_cyc - c0, STROBE_LAT);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop);
      drive_bit(1'b1);
      check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d ferr count", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d rx_data", i), u_if.rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d busy", i), u_if.busy, 1'b0);
    end

    // Start-bit glitch shorter than half a bit
    v0 = n_valid; f0 = n_ferr;
    u_if.uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    check("t2 busy during glitch", u_if.busy, 1'b1);
    repeat (50) @(negedge clk);
    u_if.uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t2 busy after glitch", u_if.busy, 1'b0);
    check("t2 no strobe", (n_valid - v0) + (n_ferr - f0), 0);

    // Bad stop bit then line held low
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b0);
    u_if.uart_rx = 1'b0;
    repeat (2000) @(negedge clk);
    check("t3 busy in break", u_if.busy, 1'b1);
    check("t3 one frame_err", n_ferr - f0, 1);
    check("t3 no valid", n_valid - v0, 0);
    check("t3 rx_data held", u_if.rx_data, 8'h3C);
    drive_bit(1'b1);
    check("t3 idle after break", u_if.busy, 1'b0);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    check("t3 recovery valid", n_valid - v0, 1);
    check("t3 recovery data", u_if.rx_data, 8'h3C);
    check("t3 still one frame_err", n_ferr - f0, 1);

    // Back-to-back frames, no idle gap
    v0 = n_valid;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    check("t4 valid count", n_valid - v0, 2);
    check("t4 first data", prev_valid_data, 8'hA5);
    check("t4 second data", last_valid_data, 8'h3C);
    check("t4 spacing", last_valid_cyc - prev_valid_cyc, FRAME_BITS * CPB);

    // Reset in the middle of bit 4 of 0xFF
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5 busy in reset", u_if.busy, 1'b0);
    check("t5 rx_data in reset", u_if.rx_data, 8'h00);
    reset = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    check("t5 no strobe", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    check("t5 valid count", n_valid - v0, 1);
    check("t5 rx_data", u_if.rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is good and 0 is bad
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1);
    drive_bit(1'b1);
    check("t6 good parity valid", n_valid - v0, 1);
    check("t6 good parity data", u_if.rx_data, 8'h07);
    check("t6 good parity perr", n_perr - p0, 0);
    v0 = n_valid; p0 = n_perr;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t6 bad parity perr", n_perr - p0, 1);
    check("t6 bad parity no valid", n_valid - v0, 0);
    check("t6 bad parity data held", u_if.rx_data, 8'h07);
`else
    check("parity_err tied low", n_perr, 0);
`endif

    check("strobes exclusive", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
